// File: rtl/detect_controller.sv
// detect_controller
// LTSSM Detect sequencer. It runs Detect.Quiet and Detect.Active, requests PIPE
// receiver detection on every lane, and collects the per-lane PhyStatus/RxStatus
// results. It reports the detected-lane mask to Polling.
// It is the initiator of the shared Timer and owns its start, enable and
// interval-code inputs.
// Every output is registered. The output registers are loaded from the decode of
// the next state, so each output lines up with DetectState in the same cycle.

module detect_controller #(
   parameter int LANES = 4
) (
   input  logic               Pclk,
   input  logic               Reset,
   input  logic               Enable,
   input  logic [LANES-1:0]   RxElecIdle,
   input  logic [LANES-1:0]   PhyStatus,
   input  logic [3*LANES-1:0] RxStatus,
   input  logic               TimeOut,
   output logic               TimerStart,
   output logic               TimerEnable,
   output logic [2:0]         TimerIntervalCode,
   output logic               TxElecIdle,
   output logic               TxDetectRx,
   output logic               DetectDone,
   output logic [LANES-1:0]   DetectedLanes,
   output logic [2:0]         DetectState
);

   // State encodings are visible on DetectState, so they are fixed values.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_QUIET    = 3'd1;
   localparam logic [2:0] ST_ACT_REQ  = 3'd2;
   localparam logic [2:0] ST_ACT_WAIT = 3'd3;
   localparam logic [2:0] ST_EVAL     = 3'd4;
   localparam logic [2:0] ST_WAIT12   = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;

   // Timer interval codes.
   localparam logic [2:0] CODE_IDLE = 3'b000;
   localparam logic [2:0] CODE_12MS = 3'b001;
   localparam logic [2:0] CODE_2MS  = 3'b100;

   // RxStatus value that means a receiver is present.
   localparam logic [2:0] RX_DETECTED = 3'b011;

   logic [2:0]       state_reg, state_next;
   logic             attempt_reg, attempt_next;
   logic [LANES-1:0] reported_reg, reported_next;
   logic [LANES-1:0] detected_reg, detected_next;
   logic [LANES-1:0] lane_found;

   logic             timer_start_reg, timer_start_next;
   logic             timer_enable_reg, timer_enable_next;
   logic [2:0]       interval_code_reg, interval_code_next;
   logic             tx_elec_idle_reg;
   logic             tx_detect_rx_reg, tx_detect_rx_next;
   logic             detect_done_reg, detect_done_next;
   logic [LANES-1:0] detected_lanes_reg, detected_lanes_next;

   logic             capture_en;
   logic             clear_results;
   logic             entering;

   // Results are only collected while the detect request is outstanding.
   // A PhyStatus pulse in any other state never touches the capture registers.
   assign capture_en    = (state_reg == ST_ACT_WAIT);
   assign clear_results = (state_reg == ST_ACT_REQ);

   // Per-lane result capture. The clear is done on the request cycle so that a
   // retry starts from a clean slate. A repeated PhyStatus on a lane overwrites
   // that lane's result with the newest RxStatus.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_found[gi] = (RxStatus[3*gi +: 3] == RX_DETECTED);

         assign reported_next[gi] = clear_results                 ? 1'b0 :
                                    (capture_en && PhyStatus[gi]) ? 1'b1 :
                                    reported_reg[gi];

         assign detected_next[gi] = clear_results                 ? 1'b0 :
                                    (capture_en && PhyStatus[gi]) ? lane_found[gi] :
                                    detected_reg[gi];
      end
   endgenerate

   // Next-state logic. Enable low overrides every other transition. Reset has
   // a still higher priority and is applied in the register block.
   always_comb begin
      state_next   = state_reg;
      attempt_next = attempt_reg;
      if (!Enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next   = ST_QUIET;
               attempt_next = 1'b0;
            end
            ST_QUIET: begin
               // A TimeOut seen while the restart pulse is still out belongs to
               // the previous interval, so it is ignored.
               if ((TimeOut && !timer_start_reg) || (RxElecIdle != '1))
                  state_next = ST_ACT_REQ;
            end
            ST_ACT_REQ: begin
               state_next = ST_ACT_WAIT;
            end
            ST_ACT_WAIT: begin
               // Look at the updated report mask. This captures a PhyStatus
               // that arrives with the watchdog TimeOut before the exit.
               if ((&reported_next) || TimeOut)
                  state_next = ST_EVAL;
            end
            ST_EVAL: begin
               if (&detected_reg) begin
                  state_next = ST_DONE;
               end else if (detected_reg == '0) begin
                  state_next   = ST_QUIET;
                  attempt_next = 1'b0;
               end else if (!attempt_reg) begin
                  state_next   = ST_WAIT12;
                  attempt_next = 1'b1;
               end else begin
                  state_next = ST_DONE;
               end
            end
            ST_WAIT12: begin
               if (TimeOut)
                  state_next = ST_ACT_REQ;
            end
            ST_DONE: begin
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state. The pulses fire on the first cycle of
   // the state they belong to.
   always_comb begin
      entering            = (state_next != state_reg);
      timer_start_next    = 1'b0;
      timer_enable_next   = 1'b0;
      interval_code_next  = CODE_IDLE;
      tx_detect_rx_next   = 1'b0;
      detect_done_next    = 1'b0;
      detected_lanes_next = '0;
      case (state_next)
         ST_QUIET, ST_WAIT12: begin
            timer_start_next   = entering;
            timer_enable_next  = 1'b1;
            interval_code_next = CODE_12MS;
         end
         ST_ACT_REQ: begin
            timer_start_next   = entering;
            timer_enable_next  = 1'b1;
            interval_code_next = CODE_2MS;
            tx_detect_rx_next  = 1'b1;
         end
         ST_ACT_WAIT: begin
            timer_enable_next  = 1'b1;
            interval_code_next = CODE_2MS;
            tx_detect_rx_next  = 1'b1;
         end
         ST_DONE: begin
            detect_done_next    = entering;
            detected_lanes_next = entering ? detected_reg : detected_lanes_reg;
         end
         default: begin
            timer_start_next = 1'b0;
         end
      endcase
   end

   // State, capture and output registers. Reset returns to IDLE with the
   // transmitter left in electrical idle.
   always_ff @(posedge Pclk) begin
      if (Reset) begin
         state_reg          <= ST_IDLE;
         attempt_reg        <= 1'b0;
         reported_reg       <= '0;
         detected_reg       <= '0;
         timer_start_reg    <= 1'b0;
         timer_enable_reg   <= 1'b0;
         interval_code_reg  <= CODE_IDLE;
         tx_elec_idle_reg   <= 1'b1;
         tx_detect_rx_reg   <= 1'b0;
         detect_done_reg    <= 1'b0;
         detected_lanes_reg <= '0;
      end else begin
         state_reg          <= state_next;
         attempt_reg        <= attempt_next;
         reported_reg       <= reported_next;
         detected_reg       <= detected_next;
         timer_start_reg    <= timer_start_next;
         timer_enable_reg   <= timer_enable_next;
         interval_code_reg  <= interval_code_next;
         tx_elec_idle_reg   <= 1'b1;
         tx_detect_rx_reg   <= tx_detect_rx_next;
         detect_done_reg    <= detect_done_next;
         detected_lanes_reg <= detected_lanes_next;
      end
   end

   assign TimerStart        = timer_start_reg;
   assign TimerEnable       = timer_enable_reg;
   assign TimerIntervalCode = interval_code_reg;
   assign TxElecIdle        = tx_elec_idle_reg;
   assign TxDetectRx        = tx_detect_rx_reg;
   assign DetectDone        = detect_done_reg;
   assign DetectedLanes     = detected_lanes_reg;
   assign DetectState       = state_reg;

endmodule

// File: tb/tb_detect_controller.sv
// Directed bench for detect_controller.
// The observed output vector is
// {DetectState, TimerStart, TimerEnable, TimerIntervalCode, TxElecIdle,
//  TxDetectRx, DetectDone, DetectedLanes}.
// It is sampled 1 ns after each rising edge of Pclk.

module tb_detect_controller;

   logic        Pclk;
   logic        Reset;
   logic        Enable;
   logic [3:0]  RxElecIdle;
   logic [3:0]  PhyStatus;
   logic [11:0] RxStatus;
   logic        TimeOut;
   logic        TimerStart;
   logic        TimerEnable;
   logic [2:0]  TimerIntervalCode;
   logic        TxElecIdle;
   logic        TxDetectRx;
   logic        DetectDone;
   logic [3:0]  DetectedLanes;
   logic [2:0]  DetectState;

   logic [14:0] obs;
   logic [14:0] exp_v;
   int          passed;
   int          total;

   localparam logic [14:0] IDLE_OUT = {3'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000};
   localparam logic [11:0] RX_ALL   = {3'b011, 3'b011, 3'b011, 3'b011};
   localparam logic [11:0] RX_0011  = {3'b000, 3'b000, 3'b011, 3'b011};
   localparam logic [11:0] RX_0001  = {3'b000, 3'b000, 3'b000, 3'b011};

   detect_controller #(.LANES(4)) dut (
      .Pclk              (Pclk),
      .Reset             (Reset),
      .Enable            (Enable),
      .RxElecIdle        (RxElecIdle),
      .PhyStatus         (PhyStatus),
      .RxStatus          (RxStatus),
      .TimeOut           (TimeOut),
      .TimerStart        (TimerStart),
      .TimerEnable       (TimerEnable),
      .TimerIntervalCode (TimerIntervalCode),
      .TxElecIdle        (TxElecIdle),
      .TxDetectRx        (TxDetectRx),
      .DetectDone        (DetectDone),
      .DetectedLanes     (DetectedLanes),
      .DetectState       (DetectState)
   );

   assign obs = {DetectState, TimerStart, TimerEnable, TimerIntervalCode,
                 TxElecIdle, TxDetectRx, DetectDone, DetectedLanes};

   initial begin
      Pclk = 1'b0;
      forever #5 Pclk = ~Pclk;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL time_limit: simulation still running, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Pclk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Enable = 1'b1;
      tick(); tick(); tick();
      exp_v = IDLE_OUT; total++;
      if (obs !== exp_v) $display("FAIL reset_hold: got %h expected %h", obs, exp_v); else begin passed++; $display("ok reset_hold %h", obs); end
      Reset = 1'b0;
      tick();
      exp_v = {3'd1, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL reset_release: got %h expected %h", obs, exp_v); else begin passed++; $display("ok reset_release %h", obs); end
   endtask

   // Starts in the first QUIET cycle left by test_reset.
   task automatic test_all_detected();
      TimeOut = 1'b1;
      tick();
      exp_v = {3'd1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL quiet_timeout_masked: got %h expected %h", obs, exp_v); else begin passed++; $display("ok quiet_timeout_masked %h", obs); end
      tick();
      exp_v = {3'd2, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL act_req: got %h expected %h", obs, exp_v); else begin passed++; $display("ok act_req %h", obs); end
      TimeOut = 1'b0;
      tick();
      exp_v = {3'd3, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL act_wait: got %h expected %h", obs, exp_v); else begin passed++; $display("ok act_wait %h", obs); end
      // Lane 0 first reports no receiver, then a duplicate report overwrites it.
      PhyStatus = 4'b0001; RxStatus = 12'h000;
      tick();
      exp_v = {3'd3, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL act_wait_one_report: got %h expected %h", obs, exp_v); else begin passed++; $display("ok act_wait_one_report %h", obs); end
      PhyStatus = 4'b1111; RxStatus = RX_ALL;
      tick();
      exp_v = {3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL eval_all: got %h expected %h", obs, exp_v); else begin passed++; $display("ok eval_all %h", obs); end
      PhyStatus = 4'b0000;
      tick();
      exp_v = {3'd6, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 4'b1111}; total++;
      if (obs !== exp_v) $display("FAIL done_all: got %h expected %h", obs, exp_v); else begin passed++; $display("ok done_all %h", obs); end
      tick();
      exp_v = {3'd6, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b1111}; total++;
      if (obs !== exp_v) $display("FAIL done_hold: got %h expected %h", obs, exp_v); else begin passed++; $display("ok done_hold %h", obs); end
      Enable = 1'b0;
      tick();
      exp_v = IDLE_OUT; total++;
      if (obs !== exp_v) $display("FAIL done_disable: got %h expected %h", obs, exp_v); else begin passed++; $display("ok done_disable %h", obs); end
   endtask

   task automatic test_partial_retry();
      Enable = 1'b1; RxStatus = 12'h000;
      tick();
      exp_v = {3'd1, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL p_quiet: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_quiet %h", obs); end
      tick();
      TimeOut = 1'b1; tick(); TimeOut = 1'b0;
      tick();
      PhyStatus = 4'b1111; RxStatus = RX_0011;
      tick();
      PhyStatus = 4'b0000;
      tick();
      exp_v = {3'd5, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL p_wait12: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_wait12 %h", obs); end
      tick();
      exp_v = {3'd5, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL p_wait12_hold: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_wait12_hold %h", obs); end
      TimeOut = 1'b1;
      tick();
      exp_v = {3'd2, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL p_retry_req: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_retry_req %h", obs); end
      TimeOut = 1'b0;
      tick();
      PhyStatus = 4'b1111; RxStatus = RX_0001;
      tick();
      exp_v = {3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL p_eval2: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_eval2 %h", obs); end
      PhyStatus = 4'b0000;
      tick();
      exp_v = {3'd6, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0001}; total++;
      if (obs !== exp_v) $display("FAIL p_done: got %h expected %h", obs, exp_v); else begin passed++; $display("ok p_done %h", obs); end
      Enable = 1'b0;
      tick();
   endtask

   // A partial result sets the retry flag. The all-zero retry then returns to
   // QUIET, which must clear the flag. A following partial result has to wait
   // in WAIT12 again instead of finishing.
   task automatic test_none_detected();
      Enable = 1'b1;
      tick(); tick();
      TimeOut = 1'b1; tick(); TimeOut = 1'b0;
      tick();
      PhyStatus = 4'b1111; RxStatus = RX_0011; tick(); PhyStatus = 4'b0000;
      tick(); tick();
      TimeOut = 1'b1; tick(); TimeOut = 1'b0;
      tick();
      PhyStatus = 4'b1111; RxStatus = 12'h000;
      tick();
      exp_v = {3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL n_eval: got %h expected %h", obs, exp_v); else begin passed++; $display("ok n_eval %h", obs); end
      PhyStatus = 4'b0000;
      tick();
      exp_v = {3'd1, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL n_requiet: got %h expected %h", obs, exp_v); else begin passed++; $display("ok n_requiet %h", obs); end
      RxElecIdle = 4'b1110;
      tick();
      exp_v = {3'd2, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL n_idle_exit: got %h expected %h", obs, exp_v); else begin passed++; $display("ok n_idle_exit %h", obs); end
      RxElecIdle = 4'b1111;
      tick();
      PhyStatus = 4'b1111; RxStatus = RX_0011; tick(); PhyStatus = 4'b0000;
      tick();
      exp_v = {3'd5, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL n_attempt_cleared: got %h expected %h", obs, exp_v); else begin passed++; $display("ok n_attempt_cleared %h", obs); end
      Enable = 1'b0;
      tick();
   endtask

   task automatic test_watchdog();
      Enable = 1'b1;
      tick(); tick();
      TimeOut = 1'b1; tick(); TimeOut = 1'b0;
      tick();
      PhyStatus = 4'b0011; RxStatus = RX_0011;
      tick();
      exp_v = {3'd3, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL w_wait_partial: got %h expected %h", obs, exp_v); else begin passed++; $display("ok w_wait_partial %h", obs); end
      PhyStatus = 4'b0000; TimeOut = 1'b1;
      tick();
      exp_v = {3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL w_eval_timeout: got %h expected %h", obs, exp_v); else begin passed++; $display("ok w_eval_timeout %h", obs); end
      TimeOut = 1'b0;
      tick();
      exp_v = {3'd5, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL w_wait12: got %h expected %h", obs, exp_v); else begin passed++; $display("ok w_wait12 %h", obs); end
      tick();
      TimeOut = 1'b1; tick(); TimeOut = 1'b0;
      tick();
      // PhyStatus and watchdog TimeOut in the same cycle: the report must count.
      PhyStatus = 4'b0001; RxStatus = RX_0001; TimeOut = 1'b1;
      tick();
      exp_v = {3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL w_same_cycle_eval: got %h expected %h", obs, exp_v); else begin passed++; $display("ok w_same_cycle_eval %h", obs); end
      PhyStatus = 4'b0000; TimeOut = 1'b0;
      tick();
      exp_v = {3'd6, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0001}; total++;
      if (obs !== exp_v) $display("FAIL w_done: got %h expected %h", obs, exp_v); else begin passed++; $display("ok w_done %h", obs); end
      Enable = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      Enable = 1'b1;
      tick();
      RxElecIdle = 4'b1110; tick(); RxElecIdle = 4'b1111;
      tick();
      exp_v = {3'd3, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 4'b0000}; total++;
      if (obs !== exp_v) $display("FAIL a_act_wait: got %h expected %h", obs, exp_v); else begin passed++; $display("ok a_act_wait %h", obs); end
      Enable = 1'b0;
      tick();
      exp_v = IDLE_OUT; total++;
      if (obs !== exp_v) $display("FAIL a_idle: got %h expected %h", obs, exp_v); else begin passed++; $display("ok a_idle %h", obs); end
      PhyStatus = 4'b1111; RxStatus = RX_ALL;
      tick();
      exp_v = IDLE_OUT; total++;
      if (obs !== exp_v) $display("FAIL a_late_phystatus: got %h expected %h", obs, exp_v); else begin passed++; $display("ok a_late_phystatus %h", obs); end
      PhyStatus = 4'b0000;
      // Reset in the middle of a detect request.
      Enable = 1'b1;
      tick();
      RxElecIdle = 4'b1110; tick(); RxElecIdle = 4'b1111;
      tick();
      Reset = 1'b1;
      tick();
      exp_v = IDLE_OUT; total++;
      if (obs !== exp_v) $display("FAIL r_mid_reset: got %h expected %h", obs, exp_v); else begin passed++; $display("ok r_mid_reset %h", obs); end
      Reset = 1'b0; Enable = 1'b0;
      tick();
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      Reset      = 1'b1;
      Enable     = 1'b0;
      RxElecIdle = 4'b1111;
      PhyStatus  = 4'b0000;
      RxStatus   = 12'h000;
      TimeOut    = 1'b0;
      test_reset();
      test_all_detected();
      test_partial_retry();
      test_none_detected();
      test_watchdog();
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
